// File: rtl/nes_dma_pkg.sv
// Shared types and constants for the CPU-side sprite DMA engine.
package nes_dma_pkg;

  // Transfer sequencer states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } dma_state_t;

  // PPU register index of OAMDATA ($2004).
  localparam logic [2:0]  PPU_OAMDATA_IDX  = 3'd4;

  // CPU address of the DMA trigger register.
  localparam logic [15:0] DMA_TRIGGER_ADDR = 16'h4014;

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA engine: a CPU write to $4014 halts the CPU and copies one
// page of CPU memory into sprite OAM, one byte per get/put cycle pair,
// through the PPU OAMDATA register.
module oam_dma
  import nes_dma_pkg::*;
#(
  parameter logic [2:0]  OAMDATA_IDX = PPU_OAMDATA_IDX,
  parameter int unsigned DMA_LEN     = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_ce,
  input  logic        dma_reg_cs,
  input  logic [7:0]  cpu_wr_data,
  output logic        cpu_rdy,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_data_in,
  output logic        ppu_reg_cs,
  output logic        ppu_reg_we,
  output logic [2:0]  ppu_reg_addr,
  output logic [7:0]  ppu_data_out,
  output logic        dma_busy,
  output logic        dma_done
);

  // Index of the final byte; the compare against it ends the transfer,
  // so idx never wraps inside a transfer.
  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  dma_state_t state_q;
  logic [7:0] page_q;
  logic [7:0] idx_q;
  logic       parity_q;
  logic       done_q;

  // Get/put parity: toggles on every CPU cycle, idle or not; 0 = get.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_q <= 1'b0;
    end else if (cpu_ce) begin
      // NOTE: sequential state is always assigned with <= so every flop
      // samples pre-edge values regardless of statement order.
      parity_q <= ~parity_q;
    end
  end

  // Transfer sequencer: page/index registers and the one-cycle done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      page_q  <= 8'h00;
      idx_q   <= 8'h00;
      done_q  <= 1'b0;
    end else if (cpu_ce) begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (dma_reg_cs) begin
            page_q  <= cpu_wr_data;
            idx_q   <= 8'h00;
            state_q <= HALT;
          end
        end
        HALT: begin
          // Reads must land on get cycles; the next cycle's parity is the
          // inverse of the current one.
          state_q <= parity_q ? READ : ALIGN;
        end
        ALIGN: begin
          state_q <= READ;
        end
        READ: begin
          state_q <= WRITE;
        end
        WRITE: begin
          if (idx_q == LAST_IDX) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end else begin
            idx_q   <= idx_q + 8'd1;
            state_q <= READ;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Status: the CPU is held off for the whole transfer.
  assign cpu_rdy  = (state_q == IDLE);
  assign dma_busy = (state_q != IDLE);
  assign dma_done = done_q;

  // Memory side: the page never carries, so $FF reads stay in $FF00-$FFFF.
  assign mem_addr = {page_q, idx_q};
  assign mem_rd   = cpu_ce && (state_q == READ);

  // PPU side: strobes last only for the enabled clock; the data path is
  // the synchronous RAM output passed straight through during WRITE.
  assign ppu_reg_cs   = cpu_ce && (state_q == WRITE);
  assign ppu_reg_we   = cpu_ce && (state_q == WRITE);
  assign ppu_reg_addr = (state_q == WRITE) ? OAMDATA_IDX : 3'd0;
  assign ppu_data_out = (state_q == WRITE) ? mem_data_in : 8'h00;

endmodule
